sclk_xfer_ctrl: RTL

Serial-transfer sequencer that owns the serial clock (sclk) and its gating relative to the transfer-request window.
- A single-cycle start request launches one DATA_W-bit full-duplex shift: MSB first out on mosi, in on miso.
- sclk toggles continuously only while a transfer is in progress, and is held low otherwise.
- Sits between the command/control logic and an off-block serial peripheral; busy is the qualifier for all sclk-activity checks.

---
 rtl/sclk_ctrl_pkg.sv | 9 +
 rtl/sclk_div_gen.sv | 28 ++
 rtl/sclk_xfer_ctrl.sv | 99 +++++++++
 3 files changed

// File: rtl/sclk_ctrl_pkg.sv
// Shared state encoding and counter-width helper for the serial transfer sequencer.
package sclk_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} xfer_state_t;

    // Width able to hold values 0..n.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction
endpackage

// File: rtl/sclk_div_gen.sv
// Half-period divider: one-cycle tick every CLK_DIV enabled cycles, restartable by clr.
module sclk_div_gen
    import sclk_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int W = cnt_w(CLK_DIV);
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end

    assign tick = en && !clr && (cnt == LAST);
endmodule

// File: rtl/sclk_xfer_ctrl.sv
// Serial transfer sequencer: owns sclk, shifts DATA_W bits MSB first per accepted start.
module sclk_xfer_ctrl
    import sclk_ctrl_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data
);
    localparam int TW = cnt_w(2 * DATA_W);
    localparam logic [TW-1:0] LAST_TOG = TW'(2 * DATA_W - 1);

    xfer_state_t       state;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic [TW-1:0]     tog_cnt;
    logic              tick;
    logic              active;

    assign active = (state == LOAD) || (state == SHIFT);
    // mosi is the shift register MSB, so it only moves when tx_sr shifts.
    assign mosi   = tx_sr[DATA_W-1];

    sclk_div_gen #(.CLK_DIV(CLK_DIV)) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == IDLE),
        .en    (active),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tx_sr   <= '0;
            rx_sr   <= '0;
            tog_cnt <= '0;
            sclk    <= 1'b0;
            cs_n    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && en) begin
                        state   <= LOAD;
                        tx_sr   <= tx_data;
                        tog_cnt <= '0;
                        sclk    <= 1'b0;
                        cs_n    <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                LOAD, SHIFT: begin
                    if (abort) begin
                        state <= IDLE;
                        sclk  <= 1'b0;
                        cs_n  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (tick && state == LOAD) begin
                        state <= SHIFT;
                    end else if (tick) begin
                        tog_cnt <= tog_cnt + 1'b1;
                        sclk    <= !sclk;
                        if (!sclk)
                            rx_sr <= {rx_sr[DATA_W-2:0], miso};
                        else if (tog_cnt != LAST_TOG)
                            tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
                        if (tog_cnt == LAST_TOG) begin
                            state   <= DONE;
                            cs_n    <= 1'b1;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            rx_data <= rx_sr;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
